// File: rtl/conv_sequencer_pkg.sv
// Shared definitions for the convolution frame sequencer: default geometry and FSM states.
package conv_sequencer_pkg;
  localparam int DEF_H_RES    = 320;
  localparam int DEF_V_RES    = 240;
  localparam int DEF_AW       = 17;
  localparam int DEF_PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/conv_sequencer_if.sv
// Handshake/address bundle between the sequencer and the memory/ALU side.
interface conv_sequencer_if #(parameter int AW = 17);
  logic          start;
  logic          hold;
  logic [AW-1:0] raddr_alu;
  logic [AW-1:0] waddr_alu;
  logic          wen_alu;
  logic          zero_out;
  logic          busy;
  logic          done;

  modport master (input start, hold,
                  output raddr_alu, waddr_alu, wen_alu, zero_out, busy, done);
  modport slave  (output start, hold,
                  input raddr_alu, waddr_alu, wen_alu, zero_out, busy, done);
endinterface

// File: rtl/conv_seq_pipe.sv
// Fixed-latency delay line carrying {addr, valid, border} from read issue to write.
module conv_seq_pipe #(
  parameter int AW       = 17,
  parameter int PIPE_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [AW-1:0] push_addr,
  input  logic          push_border,
  output logic          ret_vld,
  output logic [AW-1:0] ret_addr,
  output logic          ret_border,
  output logic          inflight
);
  logic [PIPE_LAT-1:0]         vld_pipe;
  logic [PIPE_LAT-1:0]         brd_pipe;
  logic [PIPE_LAT-1:0][AW-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      brd_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= push_vld;
      brd_pipe[0]  <= push_border;
      addr_pipe[0] <= push_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        brd_pipe[i]  <= brd_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  // Entries still travelling behind the output stage; the output stage itself retires now.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) inflight = inflight | vld_pipe[i];
  end

  assign ret_vld    = vld_pipe[PIPE_LAT-1];
  assign ret_border = brd_pipe[PIPE_LAT-1];
  assign ret_addr   = addr_pipe[PIPE_LAT-1];
endmodule

// File: rtl/conv_sequencer.sv
// Frame sequencer: walks every pixel once, issues reads, retires delayed writes.
// CONV_SEQ_BORDER_ZERO_EN: border pixels are written as zero instead of skipped.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES,
  parameter int AW       = DEF_AW,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input logic              sys_clk,
  input logic              rst,
  conv_sequencer_if.master bus
);
  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);

  seq_state_t    state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] addr;
  logic          issue, last, border;
  logic          ret_vld, ret_border, inflight;
  logic [AW-1:0] ret_addr;

  assign issue  = (state == RUN) && !bus.hold;
  assign last   = (col == COL_LAST) && (row == ROW_LAST);
  assign border = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);

  // addr tracks row*H_RES + col by plain increment; it parks on the last pixel.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      addr  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (issue && !last) begin
        addr <= addr + AW'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (issue && last) nxt = DRAIN;
      DRAIN:   if (!inflight) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  conv_seq_pipe #(.AW(AW), .PIPE_LAT(PIPE_LAT)) u_pipe (
    .clk         (sys_clk),
    .rst         (rst),
    .push_vld    (issue),
    .push_addr   (addr),
    .push_border (border),
    .ret_vld     (ret_vld),
    .ret_addr    (ret_addr),
    .ret_border  (ret_border),
    .inflight    (inflight)
  );

  assign bus.raddr_alu = addr;
  assign bus.waddr_alu = ret_addr;
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
`ifdef CONV_SEQ_BORDER_ZERO_EN
  assign bus.wen_alu   = ret_vld;
  assign bus.zero_out  = ret_vld & ret_border;
`else
  assign bus.wen_alu   = ret_vld & ~ret_border;
  assign bus.zero_out  = 1'b0;
`endif
endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized bench for conv_sequencer against a per-pixel schedule model (4x3, latency 3).
module tb_conv_sequencer;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int P  = 3;
  localparam int AW = 17;
  localparam int N  = H * V;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if #(.AW(AW)) bus ();

  conv_sequencer #(.H_RES(H), .V_RES(V), .AW(AW), .PIPE_LAT(P)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model: issue schedule per pixel, writes keyed by the cycle they must retire
  int cyc = 0;
  int m_pix = 0;
  bit m_run = 1'b0;
  bit m_active = 1'b0;
  int done_cyc = -1;
  int wr_addr[int];
  bit wr_zero[int];

  int n_wr, n_done, d_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit s, input bit h, input bit r);
    int c, ro;
    bit brd, we;
    bus.start = s;
    bus.hold  = h;
    rst       = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_run = 0; m_active = 0; m_pix = 0; done_cyc = -1;
      wr_addr.delete(); wr_zero.delete();
    end else begin
      if (m_run && !h) begin
        c = m_pix % H; ro = m_pix / H;
        brd = (c == 0) || (c == H - 1) || (ro == 0) || (ro == V - 1);
`ifdef CONV_SEQ_BORDER_ZERO_EN
        wr_addr[cyc - 1 + P] = m_pix;
        wr_zero[cyc - 1 + P] = brd;
`else
        if (!brd) wr_addr[cyc - 1 + P] = m_pix;
`endif
        if (m_pix == N - 1) begin
          m_run = 0;
          done_cyc = cyc - 1 + P + 1;
        end else m_pix++;
      end else if (!m_active && (cyc - 1) != done_cyc && s) begin
        m_active = 1; m_run = 1; m_pix = 0;
      end
      if (cyc == done_cyc) m_active = 0;
    end
    @(negedge clk);
    we = wr_addr.exists(cyc);
    chk("raddr", 32'(bus.raddr_alu), m_pix);
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("done", 32'(bus.done), 32'(cyc == done_cyc));
    chk("wen", 32'(bus.wen_alu), 32'(we));
    if (we) chk("waddr", 32'(bus.waddr_alu), wr_addr[cyc]);
`ifdef CONV_SEQ_BORDER_ZERO_EN
    chk("zero", 32'(bus.zero_out), 32'(we && wr_zero[cyc]));
`else
    chk("zero", 32'(bus.zero_out), 0);
`endif
    if (bus.wen_alu) n_wr++;
    if (bus.done) begin n_done++; d_cyc = cyc; end
  endtask

  initial begin
    int s_cyc;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // plain frame
    s_cyc = cyc; n_wr = 0; d_cyc = -1;
    step(1, 0, 0);
    for (int i = 0; i < 40 && d_cyc < 0; i++) step(0, 0, 0);
`ifdef CONV_SEQ_BORDER_ZERO_EN
    chk("frame_writes", n_wr, N);
`else
    chk("frame_writes", n_wr, (H - 2) * (V - 2));
`endif
    chk("frame_len", d_cyc - s_cyc, N + P + 1);
    step(0, 0, 0);

    // hold on frame cycles 3 and 4 stretches the frame by two
    s_cyc = cyc; d_cyc = -1;
    step(1, 0, 0);
    for (int i = 1; i < 40 && d_cyc < 0; i++) step(0, (i == 3 || i == 4), 0);
    chk("hold_len", d_cyc - s_cyc, N + P + 1 + 2);
    step(0, 0, 0);

    // start held through RUN/DRAIN/DONE gives exactly one frame
    n_done = 0;
    for (int i = 0; i < 30; i++) step(i <= N + P + 1, 0, 0);
    chk("one_frame", n_done, 1);

    // reset mid-frame abandons it
    n_done = 0;
    step(1, 0, 0);
    for (int i = 1; i < 6; i++) step(0, 0, 0);
    step(0, 0, 1);
    chk("rst_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("rst_no_done", n_done, 0);
    step(1, 0, 0);
    chk("restart_addr", 32'(bus.raddr_alu), 0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 3), ($urandom_range(0, 299) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Frame-processing controller for the convolution datapath. Walks every pixel address of the processing buffer once per frame.
- Issues read addresses to the memory controller's ALU read port (raddr_alu).
- Delays each address through a fixed pipeline matching memory-read plus ALU latency, then issues the matching write address/enable (waddr_alu, wen_alu) into the frame buffer.
- Sits between mem_controller and the ALU/kernel_ROM pair.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- AW, 17, address width; must satisfy 2^AW >= H_RES*V_RES.
- PIPE_LAT, 3, cycles from raddr_alu issue to valid ALU result (memory read latency + ALU latency), >= 1.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame-start request (from frame-ready logic).
- hold  in  1  memory port busy; suppresses issue this cycle.
- raddr_alu  out  AW  read address (centre pixel of 3x3 window).
- waddr_alu  out  AW  write address for ALU result.
- wen_alu  out  1  write enable for ALU result.
- zero_out  out  1  forces written data to 0 (border pixel); only meaningful with BORDER_ZERO_EN.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when last write retires.

Behaviour:
- Reset: state=IDLE; col, row, raddr_alu, waddr_alu = 0; wen_alu, zero_out, busy, done = 0; all pipeline valid bits cleared. Reset has priority over every other input. Reset mid-frame abandons the frame with no further writes.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN, busy=1 next cycle, col=row=0.
  - start is ignored in every other state.
- RUN, each cycle with hold=0:
  - raddr_alu = row*H_RES + col.
  - Push (addr, valid=1, border) into the pipeline; border = (row==0 | row==V_RES-1 | col==0 | col==H_RES-1).
  - Advance col. On col==H_RES-1, wrap col to 0 and increment row.
  - Issuing (H_RES-1, V_RES-1) -> DRAIN.
- RUN with hold=1:
  - raddr_alu holds and counters freeze.
  - A bubble (valid=0) is pushed; the pipeline never stalls.
- Pipeline: PIPE_LAT-deep shift register of {addr, valid, border}, registered every cycle.
  - Stage output drives waddr_alu.
  - wen_alu = valid & ~border without BORDER_ZERO_EN.
  - First write occurs exactly PIPE_LAT cycles after its read issue.
- DRAIN:
  - hold has no effect.
  - Advances until all valid bits are 0, then -> DONE.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE. A start in this cycle is ignored.
- Address arithmetic: row*H_RES computed incrementally (row base += H_RES on line wrap); no multiplier. Max address H_RES*V_RES-1 with no overflow in AW.
- Frame length with no hold: exactly H_RES*V_RES issue cycles + PIPE_LAT drain + 1 done cycle.

Optional Feature:
- Macro: CONV_SEQ_BORDER_ZERO_EN.
- Defined: border pixels are written, with wen_alu=1 and zero_out=1 in the same cycle, so the frame border is cleared to black.
- Undefined: border pixels are not written (wen_alu=0, border keeps the previous/pass-through contents); zero_out tied 0.

Decomposition:
- Shared package/header (my_header.vh): H_RES, V_RES, AW default (`awidth_fbuff), state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3).
- One natural sub-module: conv_seq_pipe. Parameterised PIPE_LAT-deep shift register carrying {addr, valid, border}, with synchronous reset clearing valid bits.

Test Plan:
- H_RES=4, V_RES=3, PIPE_LAT=3:
  - start at cycle 0 -> raddr_alu sequence 0..11 on cycles 1..12.
  - wen_alu high only for addresses 5 and 6, on cycles 9 and 10.
  - done pulse at cycle 16.
  - busy high on cycles 1..15.
- Same config, hold=1 on cycles 3-4 -> raddr_alu stays at 2 for three cycles; two bubbles appear in the write stream 3 cycles later; done is delayed by exactly 2 cycles.
- CONV_SEQ_BORDER_ZERO_EN defined -> wen_alu high for all 12 addresses; zero_out=1 for all except 5 and 6.
- rst asserted at cycle 6 mid-frame -> next cycle wen_alu=0, busy=0, state IDLE; no done pulse; fresh start restarts at address 0.
- start pulses during RUN and DONE -> ignored; exactly one frame of 12 reads.
- Default 320x240 -> final raddr_alu = 76799; final waddr_alu = 76799 (define) or last wen at 76478 (no define); no address exceeds 76799.
